// File: rtl/dma_ch_xfer.sv
// Per-channel DMA transfer engine. Fills the channel FIFO from source memory
// during the t0 phase and drains it to destination memory during the t1
// phase, moving at most BURST words per arbiter grant on a single-outstanding
// request/grant/rvalid bus.
module dma_ch_xfer #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 16,
  parameter int BURST = 4,
  parameter int LW    = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ch_en,
  input  logic          target,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] xfer_len,
  input  logic          en,
  output logic          req_done,
  output logic          t0_done,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);
  localparam logic [LW-1:0] LONE_C  = LW'(1);
  localparam logic [AW-1:0] STEP_C  = AW'(DW / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE,
    HOLD
  } state_t;

  state_t        state_reg;
  logic          ch_en_reg;
  logic [AW-1:0] rd_ptr_addr_reg;
  logic [AW-1:0] wr_ptr_addr_reg;
  logic [LW-1:0] rd_left_reg;
  logic [LW-1:0] wr_left_reg;
  logic [CW-1:0] beat_cnt_reg;

  logic          req_done_reg;
  logic          t0_done_reg;
  logic          bus_req_reg;
  logic          bus_we_reg;
  logic [AW-1:0] bus_addr_reg;
  logic [DW-1:0] bus_wdata_reg;

  // FIFO state
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          fifo_empty_reg;
  logic          fifo_full_reg;

  logic          start;
  logic          push;
  logic          pop;
  logic [CW-1:0] beat_inc;
  logic          rd_more;
  logic          wr_more;

  // A transfer starts on the registered rising edge of ch_en.
  assign start = ch_en & ~ch_en_reg;

  // The engine is single-phase per grant, so push and pop never coincide.
  assign push = (state_reg == RD_WAIT) && bus_rvalid;
  assign pop  = (state_reg == WR_REQ) && bus_gnt;

  assign beat_inc = beat_cnt_reg + ONE_C;

  // Another read fits in this grant: burst budget, words left, FIFO room.
  assign rd_more = (beat_inc < BURST_C) && (rd_left_reg > LONE_C) &&
                   ((count_reg + ONE_C) < DEPTH_C);

  // Another write fits in this grant: burst budget, FIFO data, words left.
  assign wr_more = (beat_inc < BURST_C) && (count_reg > ONE_C) &&
                   (wr_left_reg > LONE_C);

  // Next FIFO occupancy from this cycle's push or pop.
  always_comb begin
    count_next = count_reg;
    if (push) begin
      count_next = count_reg + ONE_C;
    end else if (pop) begin
      count_next = count_reg - ONE_C;
    end
  end

  // FIFO storage; no reset on the array so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= bus_rdata;
    end
  end

  // FIFO pointers, occupancy and registered empty/full flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      fifo_empty_reg <= 1'b1;
      fifo_full_reg  <= 1'b0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + PONE_C;
      end
      if (pop) begin
        head_reg <= head_reg + PONE_C;
      end
      count_reg      <= count_next;
      fifo_empty_reg <= (count_next == '0);
      fifo_full_reg  <= (count_next == DEPTH_C);
    end
  end

  // Transfer FSM with registered bus outputs, plus transfer start latching.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      ch_en_reg       <= 1'b0;
      rd_ptr_addr_reg <= '0;
      wr_ptr_addr_reg <= '0;
      rd_left_reg     <= '0;
      wr_left_reg     <= '0;
      beat_cnt_reg    <= '0;
      req_done_reg    <= 1'b0;
      t0_done_reg     <= 1'b0;
      bus_req_reg     <= 1'b0;
      bus_we_reg      <= 1'b0;
      bus_addr_reg    <= '0;
      bus_wdata_reg   <= '0;
    end else begin
      ch_en_reg    <= ch_en;
      req_done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (en) begin
            beat_cnt_reg <= '0;
            if (ch_en && !target && (rd_left_reg != '0) && !fifo_full_reg) begin
              state_reg    <= RD_REQ;
              bus_req_reg  <= 1'b1;
              bus_we_reg   <= 1'b0;
              bus_addr_reg <= rd_ptr_addr_reg;
            end else if (ch_en && target && !fifo_empty_reg && (wr_left_reg != '0)) begin
              state_reg     <= WR_REQ;
              bus_req_reg   <= 1'b1;
              bus_we_reg    <= 1'b1;
              bus_addr_reg  <= wr_ptr_addr_reg;
              bus_wdata_reg <= mem[head_reg];
            end else begin
              // Nothing to move: answer the grant without touching the bus.
              state_reg <= DONE;
            end
          end
        end

        RD_REQ: begin
          if (bus_gnt) begin
            bus_req_reg <= 1'b0;
            state_reg   <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (bus_rvalid) begin
            rd_ptr_addr_reg <= rd_ptr_addr_reg + STEP_C;
            rd_left_reg     <= rd_left_reg - LONE_C;
            beat_cnt_reg    <= beat_inc;
            if (rd_left_reg == LONE_C) begin
              t0_done_reg <= 1'b1;
            end
            if (rd_more) begin
              state_reg    <= RD_REQ;
              bus_req_reg  <= 1'b1;
              bus_addr_reg <= rd_ptr_addr_reg + STEP_C;
            end else begin
              state_reg <= DONE;
            end
          end
        end

        WR_REQ: begin
          if (bus_gnt) begin
            wr_ptr_addr_reg <= wr_ptr_addr_reg + STEP_C;
            wr_left_reg     <= wr_left_reg - LONE_C;
            beat_cnt_reg    <= beat_inc;
            if (wr_more) begin
              // The word behind the head becomes the next write data.
              bus_addr_reg  <= wr_ptr_addr_reg + STEP_C;
              bus_wdata_reg <= mem[head_reg + PONE_C];
            end else begin
              bus_req_reg <= 1'b0;
              bus_we_reg  <= 1'b0;
              state_reg   <= DONE;
            end
          end
        end

        DONE: begin
          req_done_reg <= 1'b1;
          state_reg    <= HOLD;
        end

        HOLD: begin
          // The arbiter drops en after seeing req_done; wait for it so one
          // grant never yields two bursts.
          if (!en) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase

      // A new transfer reloads addresses and word counts.
      if (start) begin
        rd_ptr_addr_reg <= src_addr;
        wr_ptr_addr_reg <= dst_addr;
        rd_left_reg     <= xfer_len;
        wr_left_reg     <= xfer_len;
        t0_done_reg     <= (xfer_len == '0);
      end
    end
  end

  assign req_done   = req_done_reg;
  assign t0_done    = t0_done_reg;
  assign fifo_empty = fifo_empty_reg;
  assign fifo_full  = fifo_full_reg;
  assign bus_req    = bus_req_reg;
  assign bus_we     = bus_we_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_wdata  = bus_wdata_reg;

endmodule

// File: doc/dma_ch_xfer.md
Name: dma_ch_xfer

Overview:
- Per-channel DMA transfer engine; one instance per channel (0..3), directly downstream of the 4-channel DMA arbiter.
- Consumes the arbiter grant `en`. When granted, it runs one bounded burst on a shared single-outstanding memory bus, then pulses `req_done`.
- Produces `t0_done`, `fifo_empty` and `fifo_full` back to the arbiter.
- Owns the channel FIFO:
  - t0 phase (`target`=0): source memory → FIFO.
  - t1 phase (`target`=1): FIFO → destination memory.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- DEPTH, 16, FIFO depth in words; power of 2, ≥2.
- BURST, 4, max words moved per grant; 1..DEPTH.
- LW, 16, width of length/count registers.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ch_en  in  1  channel enable from config regs; rising edge starts a new transfer
- target  in  1  0 = t0 phase (fill from src), 1 = t1 phase (drain to dst)
- src_addr  in  AW  source start address, byte address, word aligned
- dst_addr  in  AW  destination start address
- xfer_len  in  LW  total words; 0 means no transfer
- en  in  1  grant from arbiter; held high for the whole grant
- req_done  out  1  one-cycle pulse, burst finished
- t0_done  out  1  all xfer_len words read into FIFO
- fifo_empty  out  1  FIFO holds 0 words
- fifo_full  out  1  FIFO holds DEPTH words
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  write data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  DW  read data

Behaviour:
- Reset values: all outputs 0, except `fifo_empty`=1. FIFO pointers 0, state IDLE, counters 0, address registers 0.
- Reset is honoured at any time, including mid-burst. Any in-flight bus read is dropped and its `bus_rvalid` is ignored.
- Start:
  - On a rising edge of `ch_en` (registered compare), latch `src_addr`/`dst_addr` into rd_ptr_addr/wr_ptr_addr, `xfer_len` into rd_left/wr_left, and clear `t0_done`.
  - If `xfer_len`==0, set `t0_done`=1 on that same latch.
  - `ch_en` low: no new bursts start; a burst already in progress completes normally.
- FIFO:
  - Synchronous, DEPTH words, with a (log2(DEPTH)+1)-bit count.
  - `fifo_full` = (count==DEPTH); `fifo_empty` = (count==0). Both are registered flags, updated the same edge as the count.
  - Simultaneous push and pop cannot occur: the engine is single-phase per grant.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE, HOLD.
  - IDLE: on `en`=1 with `target`=0 → RD_REQ, provided rd_left>0 and not `fifo_full`; otherwise → DONE (empty grant). On `en`=1 with `target`=1 → WR_REQ, provided not `fifo_empty` and wr_left>0; otherwise → DONE. Set beat_cnt=0.
  - RD_REQ: `bus_req`=1, `bus_we`=0, `bus_addr`=rd_ptr_addr. On `bus_gnt` → RD_WAIT.
  - RD_WAIT: on `bus_rvalid`, push `bus_rdata`, rd_ptr_addr += DW/8, rd_left−1, beat_cnt+1.
    - If rd_left becomes 0, set `t0_done`=1 (sticky until next start).
    - Next state: RD_REQ if beat_cnt+1<BURST && rd_left−1>0 && count+1<DEPTH; else DONE.
  - WR_REQ: `bus_req`=1, `bus_we`=1, `bus_addr`=wr_ptr_addr, `bus_wdata`=FIFO head. On `bus_gnt`, pop, wr_ptr_addr += DW/8, wr_left−1, beat_cnt+1.
    - Continue in WR_REQ while beat_cnt+1<BURST && count−1>0 && wr_left−1>0; else DONE.
  - DONE: `req_done`=1 for exactly one cycle, then → HOLD.
  - HOLD: wait for `en`=0, then → IDLE. This prevents a double burst, since the arbiter drops `en` one cycle after seeing `req_done`.
- Bus outputs are registered.
  - `bus_req` stays asserted until `bus_gnt`; `bus_addr`/`bus_wdata`/`bus_we` are stable while `bus_req`=1.
  - `bus_req`=0 in every other state.
- `en` deasserting before DONE is a protocol violation. The engine still completes the burst.
- `target` is sampled only in IDLE; changes mid-burst are ignored.
- Address increments wrap modulo 2^AW.
- Latency: `en`↑ → `bus_req`↑ after 1 cycle.
- Empty grant: `en`↑ → `req_done` after 2 cycles.

Test Plan:
- Fill burst: `xfer_len`=6, `target`=0, BURST=4, zero-wait bus. Grant 1 → 4 reads at src, src+4, src+8, src+12; `req_done` pulse; count=4; `t0_done`=0. Grant 2 → 2 reads; `t0_done`=1.
- Drain: after the fill, `target`=1, 6 words in FIFO. Grants → writes to dst..dst+20 with data in read order; after the last write, `fifo_empty`=1 and wr_left=0.
- Full limit: DEPTH=4, BURST=4, `xfer_len`=10, never drain. Grant 1 fills 4 words → `fifo_full`=1. Next `target`=0 grant → no `bus_req`, `req_done` after 2 cycles.
- Bus stall: `bus_gnt` held low 5 cycles → `bus_req`/`bus_addr` held constant; no FIFO change. `bus_rvalid` delayed 3 cycles → single push.
- Handshake: `en` held high 3 cycles after `req_done` → exactly one `req_done` pulse and no new `bus_req` until `en` has gone low and high again.
- Reset mid-RD_WAIT: `rstn`=0 for 1 cycle → all outputs at reset values; a later stray `bus_rvalid` causes no push. `xfer_len`=0 start → `t0_done`=1 immediately.
